// File: rtl/led_pattern_sequencer.sv
`timescale 1ns/1ps
// LED pattern sequencer: CPU-programmable static/chase/bounce/blink generator that
// pushes only changed values to the LED PIO data register with one-cycle writes.
module led_pattern_sequencer #(
  parameter int WIDTH      = 10,
  parameter int PERIOD_W   = 24,
  parameter int PERIOD_RST = 5000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata
);

  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t              state_q, state_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [WIDTH-1:0]    pattern_q, pattern_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]    cur_q, cur_d;
  logic                dir_q, dir_d;
  logic [WIDTH-1:0]    shadow_q, shadow_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;

  logic                slave_wr;
  logic                load;
  logic                tick;
  logic [PERIOD_W-1:0] term_cnt;
  logic                unused_wdata;

  assign slave_wr     = chipselect & ~write_n;
  assign load         = slave_wr & ((address == 2'd0) | (address == 2'd1));
  assign term_cnt     = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
  assign tick         = ctrl_q[0] & (presc_q == term_cnt);
  // Upper writedata bits are architecturally ignored.
  assign unused_wdata = ^writedata;

  always_comb begin
    ctrl_d    = ctrl_q;
    pattern_d = pattern_q;
    period_d  = period_q;
    if (slave_wr) begin
      case (address)
        2'd0:    ctrl_d    = writedata[2:0];
        2'd1:    pattern_d = writedata[WIDTH-1:0];
        2'd2:    period_d  = writedata[PERIOD_W-1:0];
        default: ;
      endcase
    end

    presc_d = presc_q + PERIOD_W'(1);
    if (!ctrl_q[0] || (slave_wr && address != 2'd3) || tick) presc_d = '0;

    // A load beats a same-cycle tick; disabling blanks the LEDs regardless.
    cur_d = cur_q;
    dir_d = dir_q;
    if (!ctrl_d[0]) begin
      cur_d = '0;
    end else if (load) begin
      cur_d = pattern_d;
      dir_d = 1'b0;
    end else begin
      case (ctrl_q[2:1])
        MODE_STATIC: cur_d = pattern_q;
        MODE_CHASE:  if (tick) cur_d = {cur_q[WIDTH-2:0], cur_q[WIDTH-1]};
        MODE_BOUNCE: begin
          if (tick && cur_q != '0 && cur_q != ALL_ONES) begin
            if (!dir_q) begin
              if (cur_q[WIDTH-1]) begin
                dir_d = 1'b1;
                cur_d = cur_q >> 1;
              end else begin
                cur_d = cur_q << 1;
              end
            end else begin
              if (cur_q[0]) begin
                dir_d = 1'b0;
                cur_d = cur_q << 1;
              end else begin
                cur_d = cur_q >> 1;
              end
            end
          end
        end
        MODE_BLINK:  if (tick) cur_d = (cur_q != '0) ? '0 : pattern_q;
        default: ;
      endcase
    end
  end

  // The shadow tracks what the PIO holds, so only real changes cost a bus write.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (cur_q != shadow_q) begin
          state_d  = WRITE;
          wdata_d  = cur_q;
          shadow_d = cur_q;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[2:0]          = ctrl_q;
      2'd1: readdata[WIDTH-1:0]    = pattern_q;
      2'd2: readdata[PERIOD_W-1:0] = period_q;
      2'd3: begin
        readdata[WIDTH-1:0] = cur_q;
        readdata[16]        = dir_q;
        readdata[31]        = (state_q == WRITE);
      end
      default: ;
    endcase
  end

  assign pio_address    = 2'd0;
  assign pio_chipselect = (state_q == WRITE);
  assign pio_write_n    = (state_q != WRITE);
  assign pio_writedata  = {{(32-WIDTH){1'b0}}, wdata_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      pattern_q <= '0;
      period_q  <= PERIOD_W'(PERIOD_RST);
      presc_q   <= '0;
      cur_q     <= '0;
      dir_q     <= 1'b0;
      shadow_q  <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      pattern_q <= pattern_d;
      period_q  <= period_d;
      presc_q   <= presc_d;
      cur_q     <= cur_d;
      dir_q     <= dir_d;
      shadow_q  <= shadow_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for led_pattern_sequencer: directed scenarios with fixed
// expected LED sequences plus a randomized run against a behavioural model.
module tb_led_pattern_sequencer;

  localparam int          W     = 10;
  localparam logic [31:0] MASK  = 32'h3FF;
  localparam logic [31:0] P_RST = 32'd5000000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Behavioural model state, valid for the DUT's registered state at the current time
  logic [31:0] m_ctrl, m_pat, m_per, m_presc, m_cur, m_pio_data, m_last;
  logic        m_dir, m_pio_wr;

  // Observed PIO writes and their cycle stamps, plus the last readdata seen
  logic [31:0] wq[$];
  int          wc[$];
  logic [31:0] rd_seen;

  always #5 clk = ~clk;

  led_pattern_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address        (address),
    .chipselect     (chipselect),
    .write_n        (write_n),
    .writedata      (writedata),
    .readdata       (readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata)
  );

  function automatic void model_reset();
    m_ctrl = 0; m_pat = 0; m_per = P_RST; m_presc = 0; m_cur = 0; m_dir = 1'b0;
    m_pio_wr = 1'b0; m_pio_data = 0; m_last = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_ctrl;
      2'd1:    return m_pat;
      2'd2:    return m_per;
      default: return {m_pio_wr, 14'd0, m_dir, 6'd0, m_cur[9:0]};
    endcase
  endfunction

  // Advance the model by one clock using the LED rules in plain arithmetic
  function automatic void model_advance(input logic cs, input logic wn,
                                        input logic [1:0] a, input logic [31:0] d);
    logic        wr, tick, n_dir;
    logic [31:0] lim, n_ctrl, n_pat, n_per, n_presc, n_cur;
    wr      = cs && !wn;
    lim     = (m_per == 0) ? 32'd1 : m_per;
    tick    = m_ctrl[0] && (m_presc == lim - 32'd1);
    n_ctrl  = (wr && a == 2'd0) ? (d & 32'h7) : m_ctrl;
    n_pat   = (wr && a == 2'd1) ? (d & MASK) : m_pat;
    n_per   = (wr && a == 2'd2) ? (d & 32'hFF_FFFF) : m_per;
    n_presc = (!m_ctrl[0] || (wr && a != 2'd3) || tick) ? 32'd0 : m_presc + 32'd1;
    n_cur   = m_cur;
    n_dir   = m_dir;
    if (!n_ctrl[0]) begin
      n_cur = 0;
    end else if (wr && a < 2'd2) begin
      n_cur = n_pat;
      n_dir = 1'b0;
    end else begin
      case (m_ctrl[2:1])
        2'd0: n_cur = m_pat;
        2'd1: if (tick) n_cur = ((m_cur * 2) + (m_cur / 512)) & MASK;
        2'd2: begin
          if (tick && m_cur != 0 && m_cur != MASK) begin
            if (!m_dir) begin
              if (m_cur >= 512) begin n_dir = 1'b1; n_cur = m_cur / 2; end
              else n_cur = m_cur * 2;
            end else begin
              if (m_cur % 2 == 1) begin n_dir = 1'b0; n_cur = (m_cur * 2) & MASK; end
              else n_cur = m_cur / 2;
            end
          end
        end
        default: if (tick) n_cur = (m_cur != 0) ? 32'd0 : m_pat;
      endcase
    end
    // PIO side: a changed value goes out after one compare cycle, never back-to-back
    if (!m_pio_wr && m_cur != m_last) begin
      m_pio_wr = 1'b1; m_pio_data = m_cur; m_last = m_cur;
    end else begin
      m_pio_wr = 1'b0;
    end
    m_ctrl = n_ctrl; m_pat = n_pat; m_per = n_per; m_presc = n_presc;
    m_cur = n_cur; m_dir = n_dir;
  endfunction

  // Drive one bus cycle from just after a falling edge, record what the DUT shows
  task automatic step(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] d);
    chipselect = cs; write_n = wn; address = a; writedata = d;
    #1;
    rd_seen = readdata;
    if (pio_chipselect && !pio_write_n) begin
      wq.push_back(pio_writedata);
      wc.push_back(cyc);
    end
    model_advance(cs, wn, a, d);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 2'd3, 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd3; writedata = 0;
    repeat (2) @(negedge clk);
    model_reset();
    wq.delete(); wc.delete();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got cs=%b wn=%b wd=%h expected cs=0 wn=1 wd=0",
               pio_chipselect, pio_write_n, pio_writedata);
    end
    idle(100);
    checks++;
    if (wq.size() != 0) begin
      errors++; $display("[TB] FAIL reset_quiet: got %0d PIO writes expected 0", wq.size());
    end
    step(1'b0, 1'b1, 2'd3, 32'd0);
    checks++;
    if (rd_seen !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_status: got %h expected 0", rd_seen);
    end
    step(1'b0, 1'b1, 2'd2, 32'd0);
    checks++;
    if (rd_seen !== P_RST) begin
      errors++; $display("[TB] FAIL reset_period: got %0d expected %0d", rd_seen, P_RST);
    end
  endtask

  task automatic test_static();
    int c0;
    do_reset();
    step(1'b1, 1'b0, 2'd1, 32'h155);
    c0 = cyc;
    step(1'b1, 1'b0, 2'd0, 32'h1);
    idle(3);
    checks++;
    if (wq.size() != 1 || wq[0] !== 32'h155 || wc[0] - c0 > 3) begin
      errors++;
      $display("[TB] FAIL static_write: got %0d writes first=%h at +%0d expected 1 write of 155 within 3",
               wq.size(), (wq.size() > 0) ? wq[0] : 32'hX, (wc.size() > 0) ? wc[0] - c0 : -1);
    end
    step(1'b1, 1'b0, 2'd1, 32'h155);
    idle(5);
    checks++;
    if (wq.size() != 1) begin
      errors++; $display("[TB] FAIL static_rewrite: got %0d writes expected 1", wq.size());
    end
  endtask

  task automatic test_chase();
    logic [31:0] exp_seq[4];
    exp_seq = '{32'h201, 32'h003, 32'h006, 32'h00C};
    do_reset();
    step(1'b1, 1'b0, 2'd2, 32'd4);
    step(1'b1, 1'b0, 2'd1, 32'h201);
    step(1'b1, 1'b0, 2'd0, 32'h3);
    idle(20);
    checks++;
    if (wq.size() < 4) begin
      errors++; $display("[TB] FAIL chase_count: got %0d writes expected at least 4", wq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wq[i] !== exp_seq[i]) begin
          errors++; $display("[TB] FAIL chase_data[%0d]: got %h expected %h", i, wq[i], exp_seq[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (wc[i+1] - wc[i] != 4) begin
          errors++; $display("[TB] FAIL chase_spacing[%0d]: got %0d expected 4", i, wc[i+1] - wc[i]);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [16:0] exp_st[4];
    exp_st = '{17'h00100, 17'h00200, 17'h10100, 17'h10080};
    do_reset();
    step(1'b1, 1'b0, 2'd2, 32'd1);
    step(1'b1, 1'b0, 2'd1, 32'h100);
    step(1'b1, 1'b0, 2'd0, 32'h5);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 2'd3, 32'd0);
      checks++;
      if (rd_seen[16:0] !== exp_st[i]) begin
        errors++; $display("[TB] FAIL bounce_status[%0d]: got %h expected %h", i, rd_seen[16:0], exp_st[i]);
      end
    end
    do_reset();
    step(1'b1, 1'b0, 2'd2, 32'd1);
    step(1'b1, 1'b0, 2'd1, 32'h3FF);
    step(1'b1, 1'b0, 2'd0, 32'h5);
    idle(20);
    checks++;
    if (wq.size() != 1 || wq[0] !== 32'h3FF) begin
      errors++; $display("[TB] FAIL bounce_full: got %0d writes expected exactly one of 3FF", wq.size());
    end
  endtask

  task automatic test_blink();
    int n;
    do_reset();
    step(1'b1, 1'b0, 2'd2, 32'd3);
    step(1'b1, 1'b0, 2'd1, 32'h0F0);
    step(1'b1, 1'b0, 2'd0, 32'h7);
    idle(24);
    checks++;
    if (wq.size() < 4) begin
      errors++; $display("[TB] FAIL blink_count: got %0d writes expected at least 4", wq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wq[i] !== ((i % 2 == 0) ? 32'h0F0 : 32'h000)) begin
          errors++; $display("[TB] FAIL blink_data[%0d]: got %h expected %h", i, wq[i],
                             (i % 2 == 0) ? 32'h0F0 : 32'h000);
        end
      end
    end
    // Stop while the LEDs are lit so disabling has to drive them off
    n = 0;
    while (m_cur != 32'h0F0 && n < 10) begin
      idle(1);
      n++;
    end
    checks++;
    if (m_cur != 32'h0F0) begin
      errors++; $display("[TB] FAIL blink_wait: got timeout after %0d cycles expected lit phase", n);
    end
    idle(2);
    wq.delete(); wc.delete();
    step(1'b1, 1'b0, 2'd0, 32'h0);
    idle(20);
    checks++;
    if (wq.size() != 1 || wq[0] !== 32'h0) begin
      errors++; $display("[TB] FAIL blink_disable: got %0d writes expected exactly one of 000", wq.size());
    end
  endtask

  task automatic test_tick_collision();
    int n;
    do_reset();
    step(1'b1, 1'b0, 2'd2, 32'd4);
    step(1'b1, 1'b0, 2'd1, 32'h001);
    step(1'b1, 1'b0, 2'd0, 32'h3);
    n = 0;
    while (m_presc != 32'd3 && n < 10) begin
      idle(1);
      n++;
    end
    checks++;
    if (m_presc != 32'd3) begin
      errors++; $display("[TB] FAIL collide_wait: got timeout expected terminal count");
    end
    step(1'b1, 1'b0, 2'd1, 32'h2AA);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 2'd3, 32'd0);
      checks++;
      if (rd_seen[9:0] !== ((i < 4) ? 10'h2AA : 10'h155)) begin
        errors++; $display("[TB] FAIL collide_cur[%0d]: got %h expected %h", i, rd_seen[9:0],
                           (i < 4) ? 10'h2AA : 10'h155);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    do_reset();
    step(1'b1, 1'b0, 2'd1, 32'h0AA);
    step(1'b1, 1'b0, 2'd0, 32'h1);
    n = 0;
    while (!m_pio_wr && n < 5) begin
      idle(1);
      n++;
    end
    checks++;
    if (pio_chipselect !== 1'b1) begin
      errors++; $display("[TB] FAIL midwr_enter: got cs=%b expected 1", pio_chipselect);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1) begin
      errors++; $display("[TB] FAIL midwr_drop: got cs=%b wn=%b expected cs=0 wn=1", pio_chipselect, pio_write_n);
    end
    @(negedge clk);
    model_reset();
    wq.delete(); wc.delete();
    reset_n = 1'b1;
    step(1'b1, 1'b0, 2'd1, 32'h0AA);
    step(1'b1, 1'b0, 2'd0, 32'h1);
    idle(4);
    checks++;
    if (wq.size() != 1 || wq[0] !== 32'h0AA) begin
      errors++; $display("[TB] FAIL midwr_shadow: got %0d writes expected one write of 0AA", wq.size());
    end
  endtask

  task automatic test_random();
    logic        cs, wn;
    logic [1:0]  a;
    logic [31:0] d, exp_rd;
    int          r;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (r < 30) begin
        cs = 1'b1; wn = 1'b0;
        if (a == 2'd2) d = 32'($urandom_range(0, 6));
        else if (a == 2'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      end else begin
        cs = (r % 3 == 1); wn = (r % 3 != 2);
      end
      chipselect = cs; write_n = wn; address = a; writedata = d;
      #1;
      checks++;
      if ({pio_chipselect, pio_write_n} !== {m_pio_wr, ~m_pio_wr}) begin
        errors++; $display("[TB] FAIL rnd_strobe cycle %0d: got %b expected %b", cyc,
                           {pio_chipselect, pio_write_n}, {m_pio_wr, ~m_pio_wr});
      end
      if (m_pio_wr) begin
        checks++;
        if (pio_writedata !== m_pio_data || pio_address !== 2'd0) begin
          errors++; $display("[TB] FAIL rnd_pio_data cycle %0d: got %h@%0d expected %h@0", cyc,
                             pio_writedata, pio_address, m_pio_data);
        end
      end
      exp_rd = model_read(a);
      checks++;
      if (readdata !== exp_rd) begin
        errors++; $display("[TB] FAIL rnd_read cycle %0d addr %0d: got %h expected %h", cyc, a, readdata, exp_rd);
      end
      model_advance(cs, wn, a, d);
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_chase();
    test_bounce();
    test_blink();
    test_tick_collision();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound the whole run in case the design stalls the bench
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
